// File: rtl/oneshot_scheduler.sv
// oneshot_scheduler: round-robin sharing of one
// monostable pulse generator among N requesters.
module oneshot_scheduler #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] width_i,
  output logic           pulse,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic [N-1:0]   drop,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   clr;
  logic [N-1:0]   drop_d, grant_d, done_d;
  logic           pulse_d, busy_d;
  logic [IW-1:0]  win, scan;
  logic           hit;
  logic [W-1:0]   sel, len;

  // round-robin scan of pending starting at ptr
  always_comb begin
    win  = ptr_q;
    scan = ptr_q;
    hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      scan = IW'((int'(ptr_q) + k) % N);
      if (!hit && pending_q[scan]) begin
        hit = 1'b1;
        win = scan;
      end
    end
    sel = width_i[int'(win)*W +: W];
    len = (sel == '0) ? W'(1) : sel;
  end

  // state register, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      pulse     <= 1'b0;
      grant     <= '0;
      done      <= '0;
      drop      <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      pulse     <= pulse_d;
      grant     <= grant_d;
      done      <= done_d;
      drop      <= drop_d;
      busy      <= busy_d;
    end
  end

  // next state: arbitrate in idle, count pulse and gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    clr     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d  = S_PULSE;
          cnt_d    = len;
          owner_d  = win;
          ptr_d    = (int'(win) == N - 1) ? '0 : win + 1'b1;
          clr[win] = 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == W'(1)) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = W'(GAP);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == W'(1)) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs for the next cycle plus request capture
  always_comb begin
    pending_d = (pending_q & ~clr) | req;
    drop_d    = req & pending_q & ~clr;
    pulse_d   = (state_d == S_PULSE);
    busy_d    = (state_d != S_IDLE);
    grant_d   = '0;
    done_d    = '0;
    if (pulse_d) begin
      grant_d[owner_d] = 1'b1;
      if (cnt_d == W'(1)) done_d[owner_d] = 1'b1;
    end
  end

endmodule

// File: tb/tb_oneshot_scheduler.sv
// tb_oneshot_scheduler: directed checks of
// arbitration, timing, drop and reset behaviour.
module tb_oneshot_scheduler;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] width_i = '0;
  logic           pulse;
  logic [N-1:0]   grant, done, drop;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  oneshot_scheduler #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .width_i (width_i),
    .pulse   (pulse),
    .grant   (grant),
    .done    (done),
    .drop    (drop),
    .busy    (busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    #2;
    got = {pulse, grant, done, drop, busy};
    checks++;
    if (got !== 14'd0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", got, 14'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== 14'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%b exp=%b", c, got, 14'd0);
      end
    end
  endtask

  task automatic test_single();
    logic [13:0] got, exp;
    logic ep, eb;
    logic [3:0] eg, ed;
    do_reset();
    width_i = '0;
    width_i[2*W +: W] = 8'd5;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      ep = (c >= 2 && c <= 6) || (c >= 10 && c <= 14);
      eg = ep ? 4'b0100 : 4'b0000;
      ed = (c == 6 || c == 14) ? 4'b0100 : 4'b0000;
      eb = (c >= 2 && c <= 8) || (c >= 10 && c <= 16);
      exp = {ep, eg, ed, 4'b0000, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0 || c == 8) ? 4'b0100 : 4'b0000;
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [13:0] got, exp;
    logic eb;
    logic [3:0] eg, ed;
    do_reset();
    width_i = {4{8'd3}};
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      eg = (c >= 2 && c <= 4)   ? 4'b0001 :
           (c >= 8 && c <= 10)  ? 4'b0010 :
           (c >= 14 && c <= 16) ? 4'b1000 : 4'b0000;
      ed = (c == 4)  ? 4'b0001 :
           (c == 10) ? 4'b0010 :
           (c == 16) ? 4'b1000 : 4'b0000;
      eb = (c >= 2 && c <= 6) || (c >= 8 && c <= 12) ||
           (c >= 14 && c <= 18);
      exp = {|eg, eg, ed, 4'b0000, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL round_robin c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0) ? 4'b1011 : 4'b0000;
    end
    req = '0;
  endtask

  task automatic test_fairness();
    logic [13:0] got, exp;
    logic pc, eb, dc;
    logic [3:0] eg, edr;
    do_reset();
    width_i = {4{8'd1}};
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      pc  = (c >= 2) ? ((c - 2) % 4 == 0) : 1'b0;
      eb  = (c >= 2) ? ((c - 2) % 4 <= 2) : 1'b0;
      dc  = (c >= 3) ? ((c - 3) % 4 == 0) : 1'b0;
      eg  = !pc ? 4'b0000 :
            (((c - 2) / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
      edr = !dc ? 4'b0000 :
            (((c - 3) / 4) % 2 == 0) ? 4'b0010 : 4'b0001;
      exp = {pc, eg, eg, edr, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fairness c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0 || (pc && c <= 30)) ? 4'b0011 : 4'b0000;
    end
    req = '0;
  endtask

  task automatic test_width_extremes();
    logic [13:0] got, exp;
    logic ep, eb;
    do_reset();
    width_i = '0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      ep  = (c == 2);
      eb  = (c >= 2 && c <= 4);
      exp = {ep, ep ? 4'b0001 : 4'b0000, ep ? 4'b0001 : 4'b0000,
             4'b0000, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL width0 c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0) ? 4'b0001 : 4'b0000;
    end
    do_reset();
    width_i = '0;
    width_i[3*W +: W] = 8'd255;
    for (int c = 0; c <= 262; c++) begin
      @(negedge clk);
      ep  = (c >= 2 && c <= 256);
      eb  = (c >= 2 && c <= 258);
      exp = {ep, ep ? 4'b1000 : 4'b0000,
             (c == 256) ? 4'b1000 : 4'b0000, 4'b0000, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL width255 c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0) ? 4'b1000 : 4'b0000;
    end
    req = '0;
  endtask

  task automatic test_drop_requeue();
    logic [13:0] got, exp;
    logic eb;
    logic [3:0] eg, ed, edr;
    do_reset();
    width_i = '0;
    width_i[0*W +: W] = 8'd10;
    width_i[1*W +: W] = 8'd2;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      eg  = (c >= 2 && c <= 11)  ? 4'b0001 :
            (c >= 15 && c <= 16) ? 4'b0010 : 4'b0000;
      ed  = (c == 11) ? 4'b0001 :
            (c == 16) ? 4'b0010 : 4'b0000;
      edr = (c == 7) ? 4'b0010 : 4'b0000;
      eb  = (c >= 2 && c <= 13) || (c >= 15 && c <= 18);
      exp = {|eg, eg, ed, edr, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drop_requeue c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0) ? 4'b0001 :
            (c == 4 || c == 6) ? 4'b0010 : 4'b0000;
    end
    req = '0;
  endtask

  task automatic test_same_cycle_regrant();
    logic [13:0] got, exp;
    logic ep, eb;
    logic [3:0] ed;
    do_reset();
    width_i = '0;
    width_i[2*W +: W] = 8'd2;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      ep  = (c >= 2 && c <= 3) || (c >= 7 && c <= 8);
      ed  = (c == 3 || c == 8) ? 4'b0100 : 4'b0000;
      eb  = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
      exp = {ep, ep ? 4'b0100 : 4'b0000, ed, 4'b0000, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL same_cycle_regrant c=%0d got=%b exp=%b",
                 c, got, exp);
      end
      req = (c <= 1) ? 4'b0100 : 4'b0000;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    logic [13:0] got, exp;
    logic ep, eb;
    do_reset();
    width_i = '0;
    width_i[0*W +: W] = 8'd20;
    width_i[1*W +: W] = 8'd3;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      ep  = (c >= 2);
      exp = {ep, ep ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, ep};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0) ? 4'b0001 :
            (c == 3) ? 4'b0110 : 4'b0000;
    end
    req = '0;
    rst = 1'b1;
    #1;
    got = {pulse, grant, done, drop, busy};
    checks++;
    if (got !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", got, 14'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== 14'd0) begin
        errors++;
        $display("FAIL reset_mid_quiet c=%0d got=%b exp=%b",
                 c, got, 14'd0);
      end
    end
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      ep  = (c >= 2 && c <= 4);
      eb  = (c >= 2 && c <= 6);
      exp = {ep, ep ? 4'b0010 : 4'b0000,
             (c == 4) ? 4'b0010 : 4'b0000, 4'b0000, eb};
      got = {pulse, grant, done, drop, busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_fresh c=%0d got=%b exp=%b", c, got, exp);
      end
      req = (c == 0) ? 4'b0010 : 4'b0000;
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_width_extremes();
    test_drop_requeue();
    test_same_cycle_regrant();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
